// File: rtl/fifo_pkg.sv
// Shared constants and the RAM-access classification for the LUT-RAM FIFO controller.
package fifo_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        REFILL = 2'd2,
        BYPASS = 2'd3
    } ram_access_t;

endpackage

// File: rtl/fifo_out_stage.sv
// Output register of the FIFO: holds the head word and exposes the ob_free handshake.
module fifo_out_stage #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  out_ready,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ob_valid,
    output logic [DATA_WIDTH-1:0] ob_data,
    output logic                  ob_free
);

    logic                  ob_valid_r;
    logic [DATA_WIDTH-1:0] ob_data_r;
    logic                  ob_valid_s;
    logic [DATA_WIDTH-1:0] ob_data_s;

    // Next-state: a load always wins; otherwise a taken word empties the register.
    always_comb begin
        ob_valid_s = ob_valid_r;
        ob_data_s  = ob_data_r;
        if (load) begin
            ob_valid_s = 1'b1;
            ob_data_s  = load_data;
        end else if (out_ready) begin
            ob_valid_s = 1'b0;
        end else begin
            ob_valid_s = ob_valid_r;
        end
    end

    // Output register state; data is kept while empty so out_data holds its last value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ob_valid_r <= 1'b0;
            ob_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            ob_valid_r <= ob_valid_s;
            ob_data_r  <= ob_data_s;
        end
    end

    assign ob_valid = ob_valid_r;
    assign ob_data  = ob_data_r;
    assign ob_free  = !ob_valid_r || out_ready;

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// Valid/ready FIFO controller for a single-address LUT-RAM: one RAM access per cycle,
// arbitrating between storing input words and refilling the registered output stage.
module lutram_fifo_ctrl #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   MCNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   MCNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   MCNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_r;
    logic [ADDR_WIDTH-1:0] rptr_r;
    logic [ADDR_WIDTH:0]   mcnt_r;

    logic                  ob_valid_s;
    logic [DATA_WIDTH-1:0] ob_data_s;
    logic                  ob_free_s;
    logic                  refill_s;
    logic                  bypass_ok_s;
    logic                  in_ready_s;
    logic                  bypass_s;
    logic                  write_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;

    // Arbitration: refill beats write so the consumer is never starved while RAM holds data.
    always_comb begin
        refill_s    = ob_free_s && (mcnt_r != MCNT_ZERO);
        bypass_ok_s = ob_free_s && (mcnt_r == MCNT_ZERO);
        in_ready_s  = !refill_s && ((mcnt_r != MCNT_FULL) || bypass_ok_s);
        bypass_s    = in_valid && in_ready_s && bypass_ok_s;
        write_s     = in_valid && in_ready_s && !bypass_s;
        load_s      = refill_s || bypass_s;
        load_data_s = refill_s ? ram_dout : in_data;
    end

    // The single RAM address follows the read pointer only on a refill.
    always_comb begin
        ram_addr_s = wptr_r;
        if (refill_s) begin
            ram_addr_s = rptr_r;
        end else begin
            ram_addr_s = wptr_r;
        end
    end

    // Pointer and RAM-occupancy state; write and refill never coincide.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r <= {ADDR_WIDTH{1'b0}};
            rptr_r <= {ADDR_WIDTH{1'b0}};
            mcnt_r <= MCNT_ZERO;
        end else begin
            case ({write_s, refill_s})
                2'b10: begin
                    wptr_r <= wptr_r + PTR_ONE;
                    mcnt_r <= mcnt_r + MCNT_ONE;
                end
                2'b01: begin
                    rptr_r <= rptr_r + PTR_ONE;
                    mcnt_r <= mcnt_r - MCNT_ONE;
                end
                default: begin
                    wptr_r <= wptr_r;
                    rptr_r <= rptr_r;
                    mcnt_r <= mcnt_r;
                end
            endcase
        end
    end

    fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clock     (clock),
        .reset_n   (reset_n),
        .out_ready (out_ready),
        .load      (load_s),
        .load_data (load_data_s),
        .ob_valid  (ob_valid_s),
        .ob_data   (ob_data_s),
        .ob_free   (ob_free_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = ob_valid_s;
    assign out_data  = ob_data_s;
    assign count     = mcnt_r + {{ADDR_WIDTH{1'b0}}, ob_valid_s};
    assign ram_we    = write_s;
    assign ram_addr  = ram_addr_s;
    assign ram_din   = in_data;

endmodule
